// File: rtl/regfile_wb_arbiter_if.sv
// Purpose: bundles the two writeback source handshakes and the register-file write port.
// Latency: none, wiring only.
// Backpressure: sources hold valid and payload until ready is seen at a rising edge.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int PPP_W  = 3
);
   // ALU writeback source
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_reg;
   logic [DATA_W-1:0] alu_data;
   logic [PPP_W-1:0]  alu_ppp;

   // MEM (load / NIC return) writeback source
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_reg;
   logic [DATA_W-1:0] mem_data;
   logic [PPP_W-1:0]  mem_ppp;

   // Register-file write port and status
   logic              wb_en;
   logic [ADDR_W-1:0] wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic [PPP_W-1:0]  wb_ppp;
   logic              idle;

   // Writeback-stage side: drives requests, observes readiness and the write port
   modport master (
      output alu_valid, alu_reg, alu_data, alu_ppp,
      output mem_valid, mem_reg, mem_data, mem_ppp,
      input  alu_ready, mem_ready,
      input  wb_en, wb_reg, wb_data, wb_ppp, idle
   );

   // Arbiter side
   modport slave (
      input  alu_valid, alu_reg, alu_data, alu_ppp,
      input  mem_valid, mem_reg, mem_data, mem_ppp,
      output alu_ready, mem_ready,
      output wb_en, wb_reg, wb_data, wb_ppp, idle
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates ALU and MEM writebacks onto the single register-file write port.
// Latency: beat accepted at edge E drives wb_en from edge E+1; one write per cycle aggregate.
// Backpressure: 2-entry FIFO per source, ready = not full (no pop bypass), low during reset.

// Two-entry in-order FIFO with 1-bit wrapping pointers.
module regfile_wb_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_pop,
   output logic [W-1:0] out_dat
);
   logic [W-1:0] store [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         push;
   logic         pop;

   // A full FIFO refuses a beat even if it pops on the same edge.
   assign in_rdy  = (count != 2'd2) && !rst;
   assign out_vld = (count != 2'd0);
   assign push    = in_vld && in_rdy;
   assign pop     = out_pop && out_vld;
   assign out_dat = store[rd_ptr];

   // Pointer and occupancy tracking; reset drops everything queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= in_dat;
   end
endmodule

module regfile_wb_arbiter #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 5,
   parameter int PPP_W      = 3,
   parameter int STARVE_MAX = 3
) (
   input logic                clk,
   input logic                rst,
   regfile_wb_arbiter_if.slave bus
);
   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
      logic [PPP_W-1:0]  ppp;
   } wb_beat_t;

   localparam int BEAT_W = $bits(wb_beat_t);
   localparam int CNT_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   wb_beat_t         alu_in;
   wb_beat_t         mem_in;
   wb_beat_t         alu_head;
   wb_beat_t         mem_head;
   wb_beat_t         winner;
   logic             alu_hv;
   logic             mem_hv;
   logic             grant_alu;
   logic             grant_mem;
   logic             has_winner;
   logic [CNT_W-1:0] starve;

   assign alu_in = {bus.alu_reg, bus.alu_data, bus.alu_ppp};
   assign mem_in = {bus.mem_reg, bus.mem_data, bus.mem_ppp};

   regfile_wb_fifo #(.W(BEAT_W)) u_alu_fifo (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (bus.alu_valid),
      .in_rdy  (bus.alu_ready),
      .in_dat  (alu_in),
      .out_vld (alu_hv),
      .out_pop (grant_alu),
      .out_dat (alu_head)
   );

   regfile_wb_fifo #(.W(BEAT_W)) u_mem_fifo (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (bus.mem_valid),
      .in_rdy  (bus.mem_ready),
      .in_dat  (mem_in),
      .out_vld (mem_hv),
      .out_pop (grant_mem),
      .out_dat (mem_head)
   );

   // ALU wins ties unless the MEM head has already lost STARVE_MAX times in a row.
   always_comb begin
      grant_mem  = mem_hv && (!alu_hv || (starve == STARVE_LIM));
      grant_alu  = alu_hv && !grant_mem;
      has_winner = grant_alu || grant_mem;
      winner     = grant_mem ? mem_head : alu_head;
   end

   // Count consecutive lost arbitrations of a waiting MEM head, saturating at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve <= '0;
      end else if (!mem_hv || grant_mem) begin
         starve <= '0;
      end else if (grant_alu && (starve != STARVE_LIM)) begin
         starve <= starve + CNT_W'(1);
      end
   end

   // Registered write request; register 0 is consumed without enabling a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.wb_en   <= 1'b0;
         bus.wb_reg  <= '0;
         bus.wb_data <= '0;
         bus.wb_ppp  <= '0;
      end else begin
         bus.wb_en <= has_winner && (winner.rd != '0);
         if (has_winner) begin
            bus.wb_reg  <= winner.rd;
            bus.wb_data <= winner.data;
            bus.wb_ppp  <= winner.ppp;
         end
      end
   end

   assign bus.idle = !alu_hv && !mem_hv && !bus.wb_en;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: self-checking bench for regfile_wb_arbiter with a per-source scoreboard.
// Latency: expected writes queued at acceptance, retired when wb_en is observed.
// Backpressure: source tasks hold valid until ready is sampled, bounded per beat.
module tb_regfile_wb_arbiter;
   localparam int DATA_W     = 64;
   localparam int ADDR_W     = 5;
   localparam int PPP_W      = 3;
   localparam int STARVE_MAX = 3;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
      logic [PPP_W-1:0]  ppp;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PPP_W(PPP_W)) bus ();

   regfile_wb_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PPP_W(PPP_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // MEM beats carry data bit 63 set so the monitor can tell the sources apart.
   beat_t exp_alu[$];
   beat_t exp_mem[$];
   logic  src_log[$];
   beat_t mon_got;
   beat_t mon_exp;
   int    errors = 0;
   int    checks = 0;
   int    wr_count = 0;
   int    wb_run = 0;
   int    max_run = 0;
   int    alu_stalls = 0;
   int    mem_stalls = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Retire every observed write against the scoreboard of its source.
   always @(negedge clk) begin
      if (!rst && bus.wb_en === 1'b1) begin
         wr_count++;
         wb_run++;
         if (wb_run > max_run) max_run = wb_run;
         mon_got.rd   = bus.wb_reg;
         mon_got.data = bus.wb_data;
         mon_got.ppp  = bus.wb_ppp;
         src_log.push_back(bus.wb_data[63]);
         if (bus.wb_data[63]) begin
            if (exp_mem.size() == 0) check_val("sb_mem_unexpected", exp_mem.size(), 1);
            else begin
               mon_exp = exp_mem.pop_front();
               check_val("sb_mem_beat", mon_got, mon_exp);
            end
         end else begin
            if (exp_alu.size() == 0) check_val("sb_alu_unexpected", exp_alu.size(), 1);
            else begin
               mon_exp = exp_alu.pop_front();
               check_val("sb_alu_beat", mon_got, mon_exp);
            end
         end
      end else begin
         wb_run = 0;
      end
   end

   // Present one beat from a source; returns 1 time unit after the accepting edge.
   task automatic send(input bit is_mem, input logic [ADDR_W-1:0] rd,
                       input logic [DATA_W-1:0] data, input logic [PPP_W-1:0] ppp);
      int    n = 0;
      bit    acc = 1'b0;
      beat_t b;
      b.rd = rd; b.data = data; b.ppp = ppp;
      if (is_mem) begin
         bus.mem_valid = 1'b1; bus.mem_reg = rd; bus.mem_data = data; bus.mem_ppp = ppp;
      end else begin
         bus.alu_valid = 1'b1; bus.alu_reg = rd; bus.alu_data = data; bus.alu_ppp = ppp;
      end
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = is_mem ? bus.mem_ready : bus.alu_ready;
         if (!acc) begin
            if (is_mem) mem_stalls++;
            else        alu_stalls++;
         end
         @(posedge clk);
         n++;
      end
      if (!acc) check_val(is_mem ? "mem_send_timeout" : "alu_send_timeout", acc, 1);
      else if (rd != '0) begin
         if (is_mem) exp_mem.push_back(b);
         else        exp_alu.push_back(b);
      end
      #1;
      if (is_mem) bus.mem_valid = 1'b0;
      else        bus.alu_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_alu.size() != 0 || exp_mem.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check_val(tag, exp_alu.size() + exp_mem.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0; bus.alu_ppp = '0;
      bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0; bus.mem_ppp = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_wb_en", bus.wb_en, 0);
      check_val("rst_wb_reg", bus.wb_reg, 0);
      check_val("rst_alu_ready", bus.alu_ready, 0);
      check_val("rst_mem_ready", bus.mem_ready, 0);
      check_val("rst_idle", bus.idle, 1);
      rst = 1'b0;
      #1;
      check_val("rel_alu_ready", bus.alu_ready, 1);
      check_val("rel_mem_ready", bus.mem_ready, 1);
      @(posedge clk);
      #1;

      // Single ALU beat: write visible only in the cycle after acceptance
      send(1'b0, 5'd5, 64'hDEAD_BEEF, 3'd0);
      check_val("single_e0_wb_en", bus.wb_en, 0);
      @(posedge clk);
      #1;
      check_val("single_e1_wb_en", bus.wb_en, 1);
      check_val("single_e1_wb_reg", bus.wb_reg, 5);
      check_val("single_e1_wb_data", bus.wb_data, 64'hDEAD_BEEF);
      @(posedge clk);
      #1;
      check_val("single_e2_wb_en", bus.wb_en, 0);
      wait_drain("single_drain");

      // Back-to-back ALU stream of 6 beats
      alu_stalls = 0;
      max_run = 0;
      for (int i = 0; i < 6; i++) send(1'b0, 5'(i + 1), 64'h100 + 64'(i), 3'(i));
      wait_drain("b2b_drain");
      check_val("b2b_alu_stalls", alu_stalls, 0);
      check_val("b2b_run_len", max_run, 6);

      // Both sources continuously valid: A,A,A,M grant pattern
      src_log.delete();
      fork
         for (int i = 0; i < 12; i++) send(1'b0, 5'(8 + i), 64'h200 + 64'(i), 3'(i));
         for (int j = 0; j < 4; j++) send(1'b1, 5'(24 + j), 64'h8000_0000_0000_0300 + 64'(j), 3'(j + 1));
      join
      wait_drain("starve_drain");
      check_val("starve_writes", src_log.size(), 16);
      for (int k = 0; k < src_log.size() && k < 16; k++)
         check_val($sformatf("starve_grant_%0d", k), src_log[k], (k % 4 == 3) ? 1 : 0);

      // MEM held off by a full ALU stream
      mem_stalls = 0;
      fork
         for (int i = 0; i < 8; i++) send(1'b0, 5'(3 + i), 64'h400 + 64'(i), 3'(i));
         for (int j = 0; j < 3; j++) send(1'b1, 5'(16 + j), 64'h8000_0000_0000_0500 + 64'(j), 3'(7 - j));
         begin
            repeat (2) @(posedge clk);
            #1;
            check_val("hold_mem_ready_full", bus.mem_ready, 0);
         end
      join
      wait_drain("hold_drain");
      check_val("hold_mem_waited", (mem_stalls > 0) ? 1 : 0, 1);

      // Register 0 beat consumed without a write, then register 7 written
      send(1'b0, 5'd0, 64'h77, 3'd1);
      send(1'b0, 5'd7, 64'h7777, 3'd2);
      check_val("reg0_wb_en", bus.wb_en, 0);
      @(posedge clk);
      #1;
      check_val("reg7_wb_en", bus.wb_en, 1);
      check_val("reg7_wb_reg", bus.wb_reg, 7);
      wait_drain("reg0_drain");
      check_val("reg0_idle", bus.idle, 1);

      // Reset mid-stream with two beats queued
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd9;  bus.alu_data = 64'h900; bus.alu_ppp = 3'd1;
      bus.mem_valid = 1'b1; bus.mem_reg = 5'd10; bus.mem_data = 64'h8000_0000_0000_0A00; bus.mem_ppp = 3'd2;
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
      bus.alu_reg = 5'd11; bus.alu_data = 64'hB00;
      @(posedge clk);
      #1;
      bus.alu_valid = 1'b0;
      check_val("midrst_pre_wb_en", bus.wb_en, 1);
      rst = 1'b1;
      #1;
      check_val("midrst_wb_en", bus.wb_en, 0);
      check_val("midrst_alu_ready", bus.alu_ready, 0);
      check_val("midrst_mem_ready", bus.mem_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wr_count = 0;
      #1;
      check_val("postrst_alu_ready", bus.alu_ready, 1);
      check_val("postrst_mem_ready", bus.mem_ready, 1);
      check_val("postrst_idle", bus.idle, 1);
      repeat (5) @(posedge clk);
      #1;
      check_val("postrst_no_stale_write", wr_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
